bps_filter_ctrl: RTL and testbench

- Sequencing controller for the time-multiplexed FIR band-pass filter in the QAM receive path.
- Accepts one input-sample strobe at a time and writes the sample into a circular delay-line RAM.
- Drives a single shared MAC over NTAPS taps, issuing delay-line and coefficient read addresses plus MAC control.
- Arbitrates the single-port coefficient RAM between filter reads and host coefficient writes.

---
 rtl/bps_filter_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bps_filter_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bps_filter_ctrl.sv
// -----------------------------------------------------------------------------
// bps_filter_ctrl
// Sequencing controller for a time-multiplexed FIR band-pass filter.
// Each accepted sample is written into a circular delay-line RAM, then a single
// shared MAC is stepped over NTAPS taps, flushed for MAC_LAT cycles, and the
// result is flagged with a one-cycle out_valid pulse. The single-port
// coefficient RAM is handed to the host only while the controller is idle.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   smp_valid/ready     sample strobe / controller idle
//   coef_wr_req/grant   host coefficient write request / permission
//   dl_we, dl_waddr     delay-line write
//   dl_raddr            delay-line read address (tap 0 = newest sample)
//   coef_raddr          coefficient read address (= tap index)
//   mac_clr/en/last     MAC control
//   out_valid           MAC result valid pulse
//   overrun             sticky: a sample arrived while busy and was dropped
// -----------------------------------------------------------------------------
module bps_filter_ctrl #(
    parameter int NTAPS   = 32,
    parameter int AW      = 5,
    parameter int MAC_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          smp_valid,
    output logic          smp_ready,
    input  logic          coef_wr_req,
    output logic          coef_wr_grant,
    output logic          dl_we,
    output logic [AW-1:0] dl_waddr,
    output logic [AW-1:0] dl_raddr,
    output logic [AW-1:0] coef_raddr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_last,
    output logic          out_valid,
    output logic          overrun
);

    // Flush counter only has to hold MAC_LAT-1.
    localparam int FW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);
    localparam logic [AW-1:0] K_LAST  = AW'(NTAPS - 1);
    localparam logic [FW-1:0] FL_INIT = FW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] k_q, k_d;
    logic [FW-1:0] fl_q, fl_d;
    logic          overrun_q, overrun_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            wptr_q    <= {AW{1'b0}};
            k_q       <= {AW{1'b0}};
            fl_q      <= {FW{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            k_q       <= k_d;
            fl_q      <= fl_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        k_d       = k_q;
        fl_d      = fl_q;
        // A sample offered while busy is lost; the running sequence ignores it.
        overrun_d = overrun_q | (smp_valid & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (smp_valid) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // Pointer advances here, so during RUN wptr-1 is the newest entry.
                wptr_d  = wptr_q + {{(AW-1){1'b0}}, 1'b1};
                k_d     = {AW{1'b0}};
                state_d = RUN;
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    k_d     = {AW{1'b0}};
                    fl_d    = FL_INIT;
                    state_d = FLUSH;
                end else begin
                    k_d = k_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            FLUSH: begin
                if (fl_q == {FW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    fl_d = fl_q - {{(FW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs decoded from state/counters, forced low during reset.
    always_comb begin
        smp_ready     = 1'b0;
        coef_wr_grant = 1'b0;
        dl_we         = 1'b0;
        dl_waddr      = {AW{1'b0}};
        dl_raddr      = {AW{1'b0}};
        coef_raddr    = {AW{1'b0}};
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        mac_last      = 1'b0;
        out_valid     = 1'b0;
        overrun       = 1'b0;
        if (!reset) begin
            overrun = overrun_q;
            case (state_q)
                IDLE: begin
                    smp_ready     = 1'b1;
                    // A sample wins over a host write in the same cycle.
                    coef_wr_grant = coef_wr_req & ~smp_valid;
                end
                WRITE: begin
                    dl_we    = 1'b1;
                    dl_waddr = wptr_q;
                end
                RUN: begin
                    mac_en     = 1'b1;
                    dl_raddr   = wptr_q - {{(AW-1){1'b0}}, 1'b1} - k_q;
                    coef_raddr = k_q;
                    mac_clr    = (k_q == {AW{1'b0}});
                    mac_last   = (k_q == K_LAST);
                end
                FLUSH: begin
                    mac_en = 1'b0;
                end
                DONE: begin
                    out_valid = 1'b1;
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end else begin
            overrun = 1'b0;
        end
    end

endmodule

// File: tb/tb_bps_filter_ctrl.sv
// Directed bench for bps_filter_ctrl (defaults NTAPS=32, AW=5, MAC_LAT=2).
// A small delay-line/coefficient/MAC model is driven from the DUT's own
// control outputs, so output values depend on the addresses the DUT issues.
module tb_bps_filter_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       smp_valid = 1'b0;
    logic       smp_ready;
    logic       coef_wr_req = 1'b0;
    logic       coef_wr_grant;
    logic       dl_we;
    logic [4:0] dl_waddr;
    logic [4:0] dl_raddr;
    logic [4:0] coef_raddr;
    logic       mac_clr;
    logic       mac_en;
    logic       mac_last;
    logic       out_valid;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int         dl_mem [32];
    int         coef_mem [32];
    int         acc = 0;
    logic [4:0] exp_wptr = 5'd0;
    logic       ovr_exp = 1'b0;

    bps_filter_ctrl #(.NTAPS(32), .AW(5), .MAC_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .coef_wr_req(coef_wr_req), .coef_wr_grant(coef_wr_grant),
        .dl_we(dl_we), .dl_waddr(dl_waddr), .dl_raddr(dl_raddr),
        .coef_raddr(coef_raddr), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_last(mac_last), .out_valid(out_valid), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, smp_ready, coef_wr_grant, dl_we, dl_waddr, dl_raddr,
                coef_raddr, mac_clr, mac_en, mac_last, out_valid, overrun};
    endfunction

    // One complete sample sequence, cycle 0 = accept cycle.
    // drop_c: cycle to offer an extra (dropped) sample, -1 for none.
    // rst_c : cycle to pulse reset and abandon the sequence, -1 for none.
    task automatic do_sample(input int val, input int exp_out, input int drop_c,
                             input bit req_hold, input int rst_c);
        logic [4:0] er;
        bit         run;
        for (int c = 0; c < 38; c++) begin
            @(negedge clock);
            if (c == rst_c) begin
                reset = 1'b1; smp_valid = 1'b0; coef_wr_req = 1'b0;
                #1;
                chk("abort_reset_outputs", all_outs(), 32'd0);
                @(negedge clock);
                reset = 1'b0;
                exp_wptr = 5'd0;
                ovr_exp = 1'b0;
                return;
            end
            smp_valid   = (c == 0) || (c == drop_c);
            coef_wr_req = req_hold;
            #1;
            run = (c >= 2) && (c <= 33);
            er  = run ? (exp_wptr - 5'd1 - 5'(c - 2)) : 5'd0;
            chk("smp_ready", {31'd0, smp_ready}, {31'd0, (c == 0) || (c == 37)});
            chk("coef_wr_grant", {31'd0, coef_wr_grant}, {31'd0, req_hold && (c == 37)});
            chk("dl_we", {31'd0, dl_we}, {31'd0, c == 1});
            if (c == 1) chk("dl_waddr", {27'd0, dl_waddr}, {27'd0, exp_wptr});
            chk("mac_en", {31'd0, mac_en}, {31'd0, run});
            chk("mac_clr", {31'd0, mac_clr}, {31'd0, c == 2});
            chk("mac_last", {31'd0, mac_last}, {31'd0, c == 33});
            chk("dl_raddr", {27'd0, dl_raddr}, {27'd0, er});
            chk("coef_raddr", {27'd0, coef_raddr}, run ? 32'(c - 2) : 32'd0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, c == 36});
            chk("overrun", {31'd0, overrun}, {31'd0, ovr_exp});
            if (c == 36) chk("mac_result", 32'(acc), 32'(exp_out));
            // datapath model follows DUT controls
            if (dl_we) dl_mem[dl_waddr] = val;
            if (mac_en) begin
                if (mac_clr) acc = dl_mem[dl_raddr] * coef_mem[coef_raddr];
                else         acc = acc + dl_mem[dl_raddr] * coef_mem[coef_raddr];
            end
            if (c == 1) exp_wptr = exp_wptr + 5'd1;
            if (c == drop_c) ovr_exp = 1'b1;
        end
        smp_valid = 1'b0;
        coef_wr_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            dl_mem[i]   = 0;
            coef_mem[i] = i + 1;
        end

        // Reset holds every output low even with both requests present.
        smp_valid = 1'b1; coef_wr_req = 1'b1;
        @(negedge clock); #1;
        chk("reset_outputs_a", all_outs(), 32'd0);
        @(negedge clock); #1;
        chk("reset_outputs_b", all_outs(), 32'd0);
        @(negedge clock);
        reset = 1'b0; smp_valid = 1'b0; coef_wr_req = 1'b1;
        #1;
        chk("idle_ready", {31'd0, smp_ready}, 32'd1);
        chk("idle_grant", {31'd0, coef_wr_grant}, 32'd1);
        chk("idle_overrun", {31'd0, overrun}, 32'd0);
        coef_wr_req = 1'b0;

        // Impulse through 40 back-to-back samples: 1..32, then 0 after wrap.
        do_sample(1, 1, -1, 1'b0, -1);
        for (int n = 2; n <= 40; n++)
            do_sample(0, (n <= 32) ? n : 0, -1, 1'b0, -1);

        // Sample offered during RUN is dropped; overrun latches.
        do_sample(5, 5, 12, 1'b0, -1);

        // Host write held high throughout: granted only in idle, loses to sample.
        do_sample(3, 13, -1, 1'b1, -1);

        // Reset at RUN k=10 aborts; no result follows.
        do_sample(9, 0, -1, 1'b0, 12);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock); #1;
            chk("post_abort_ready", {31'd0, smp_ready}, 32'd1);
            chk("post_abort_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Next sample lands at address 0; older entries 9,3,5 sit at taps 22..24.
        do_sample(7, 7 + 9 * 23 + 3 * 24 + 5 * 25, -1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
